// File: rtl/alu_md_if.sv
// alu_md_if: EX-stage instruction/result bundle between the pipeline and alu_md_exec
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             stall_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master (
    output valid_i, flush_i, aluop, funct, src_a, src_b,
    input  result, zero, overflow, stall_o, hi_o, lo_o
  );
  modport slave (
    input  valid_i, flush_i, aluop, funct, src_a, src_b,
    output result, zero, overflow, stall_o, hi_o, lo_o
  );
endinterface

// File: rtl/alu_md_exec.sv
// alu_md_exec: MIPS EX unit, single-cycle ALU plus multi-cycle mult/div with HI/LO and stall; ALU_MD_DIV_EARLY_EN enables early divide exit
module alu_md_exec #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic   clk,
  input  logic   resetn,
  alu_md_if.slave bus
);
  localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLTU = 6'b101011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic             is_r, is_mul, is_div, md_signed, accept, stall;
  logic [WIDTH-1:0] a, b, sum, dif, res, abs_a, abs_b, rem_nx, quo_nx, q_fin, r_fin;
  logic [2*WIDTH-1:0] xa, xb, prod;
  logic [WIDTH:0]   sh;
  logic             ge, ovf;
  assign a         = bus.src_a;
  assign b         = bus.src_b;
  assign sum       = a + b;
  assign dif       = a - b;
  assign is_r      = bus.valid_i && bus.aluop == 2'b10;
  assign is_mul    = is_r && bus.funct[5:1] == 5'b01100;
  assign is_div    = is_r && bus.funct[5:1] == 5'b01101;
  assign md_signed = !bus.funct[0];
  assign accept    = state_q == IDLE && !bus.flush_i && (is_mul || is_div);
  assign stall     = resetn && (accept || state_q == MUL || state_q == DIV);
  assign abs_a     = (md_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (md_signed && b[WIDTH-1]) ? -b : b;
  // Product from the latched operands, sign- or zero-extended to full width
  always_comb begin
    xa   = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
    xb   = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
    prod = xa * xb;
  end
  // One restoring-division step; opa_q shifts the dividend out and the quotient in
  always_comb begin
    sh     = {rem_q, opa_q[WIDTH-1]};
    ge     = sh >= {1'b0, opb_q};
    rem_nx = ge ? sh[WIDTH-1:0] - opb_q : sh[WIDTH-1:0];
    quo_nx = {opa_q[WIDTH-2:0], ge};
    q_fin  = (opb_q == '0) ? '1 : (qneg_q ? -quo_nx : quo_nx);
    r_fin  = rneg_q ? -rem_nx : rem_nx;
  end
  // Single-cycle result mux; idle or invalid slots read as zero
  always_comb begin
    res = '0;
    if (bus.valid_i)
      case (bus.aluop)
        2'b00: res = sum;
        2'b01: res = dif;
        2'b10:
          case (bus.funct)
            F_ADD, F_ADDU: res = sum;
            F_SUB, F_SUBU: res = dif;
            F_AND:  res = a & b;
            F_OR:   res = a | b;
            F_XOR:  res = a ^ b;
            F_NOR:  res = ~(a | b);
            F_SLT:  res = WIDTH'($signed(a) < $signed(b));
            F_SLTU: res = WIDTH'(a < b);
            F_MFHI: res = hi_q;
            F_MFLO: res = lo_q;
            default: res = '0;
          endcase
        default: res = '0;
      endcase
    ovf = is_r && ((bus.funct == F_ADD && a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) ||
                   (bus.funct == F_SUB && a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1]));
  end
  // Multiply/divide sequencer and HI/LO update; flush aborts without touching HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (is_r && !stall && bus.funct == F_MTHI) hi_d = a;
    if (is_r && !stall && bus.funct == F_MTLO) lo_d = a;
    case (state_q)
      IDLE:
        if (accept && is_mul) begin
          opa_d   = a;
          opb_d   = b;
          sgn_d   = md_signed;
          cnt_d   = CW'(MUL_STAGES - 1);
          state_d = MUL;
        end else if (accept) begin
          opa_d   = abs_a;
          opb_d   = abs_b;
          rem_d   = '0;
          qneg_d  = md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = md_signed && a[WIDTH-1];
          cnt_d   = CW'(WIDTH - 1);
          state_d = DIV;
`ifdef ALU_MD_DIV_EARLY_EN
          if (abs_b == '0 || abs_a < abs_b) begin
            hi_d    = a;
            lo_d    = (abs_b == '0) ? '1 : '0;
            state_d = DONE;
          end
`else
`endif
        end
      MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (bus.flush_i) state_d = IDLE;
        else if (cnt_q == '0) begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 1'b1;
        opa_d = quo_nx;
        rem_d = rem_nx;
        if (bus.flush_i) state_d = IDLE;
        else if (cnt_q == '0) begin
          hi_d    = r_fin;
          lo_d    = q_fin;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  assign bus.result   = res;
  assign bus.zero     = res == '0;
  assign bus.overflow = ovf;
  assign bus.stall_o  = stall;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;
endmodule

// File: tb/tb_alu_md_exec.sv
// tb_alu_md_exec: directed checks of alu_md_exec ALU ops, mult/div timing, flush and async reset
module tb_alu_md_exec;
  logic clk, resetn;
  int total, bad, n;
  alu_md_if #(.WIDTH(32)) bus ();
  alu_md_exec #(.WIDTH(32), .MUL_STAGES(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = v;
    bus.aluop   = op;
    bus.funct   = f;
    bus.src_a   = a;
    bus.src_b   = b;
  endtask
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int cycles);
    drive(1'b1, 2'b10, f, a, b);
    #1;
    cycles = 0;
    while (bus.stall_o && cycles < 100) begin
      cycles++;
      tick();
      #1;
    end
  endtask
  initial begin
    total = 0;
    bad = 0;
    resetn = 1'b1;
    bus.flush_i = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    #1 resetn = 1'b0;
    #2;
    check("rst_hi", bus.hi_o, 0);
    check("rst_lo", bus.lo_o, 0);
    check("rst_stall", bus.stall_o, 0);
    check("rst_result", bus.result, 0);
    tick();
    resetn = 1'b1;
    tick();
    drive(1'b1, 2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1); #1;
    check("add_res", bus.result, 32'h80000000);
    check("add_ovf", bus.overflow, 1);
    check("add_zero", bus.zero, 0);
    check("add_stall", bus.stall_o, 0);
    drive(1'b1, 2'b00, 6'b100000, 32'h7FFFFFFF, 32'd1); #1;
    check("op00_res", bus.result, 32'h80000000);
    check("op00_ovf", bus.overflow, 0);
    drive(1'b1, 2'b01, 6'd0, 32'd5, 32'd5); #1;
    check("op01_res", bus.result, 0);
    check("op01_zero", bus.zero, 1);
    drive(1'b1, 2'b10, 6'b100010, 32'h80000000, 32'd1); #1;
    check("sub_res", bus.result, 32'h7FFFFFFF);
    check("sub_ovf", bus.overflow, 1);
    drive(1'b1, 2'b10, 6'b100011, 32'h80000000, 32'd1); #1;
    check("subu_ovf", bus.overflow, 0);
    drive(1'b1, 2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00); #1;
    check("and", bus.result, 32'hF000F000);
    drive(1'b1, 2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00); #1;
    check("or", bus.result, 32'hFFF0FFF0);
    drive(1'b1, 2'b10, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00); #1;
    check("xor", bus.result, 32'h0FF00FF0);
    drive(1'b1, 2'b10, 6'b100111, 32'd0, 32'd0); #1;
    check("nor", bus.result, 32'hFFFFFFFF);
    drive(1'b1, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1); #1;
    check("slt", bus.result, 1);
    drive(1'b1, 2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1); #1;
    check("sltu", bus.result, 0);
    check("sltu_zero", bus.zero, 1);
    drive(1'b1, 2'b11, 6'b100000, 32'd3, 32'd4); #1;
    check("op11", bus.result, 0);
    drive(1'b1, 2'b10, 6'b111111, 32'd3, 32'd4); #1;
    check("unk_funct", bus.result, 0);
    drive(1'b0, 2'b00, 6'd0, 32'd3, 32'd4); #1;
    check("invalid", bus.result, 0);
    tick();
    run_md(6'b011000, 32'hFFFFFFFD, 32'd5, n);
    check("mult_stall", n, 3);
    check("mult_hi", bus.hi_o, 32'hFFFFFFFF);
    check("mult_lo", bus.lo_o, 32'hFFFFFFF1);
    drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0); #1;
    check("mflo_done", bus.result, 32'hFFFFFFF1);
    tick();
    run_md(6'b011010, 32'hFFFFFFF9, 32'd2, n);
    check("div_stall", n, 33);
    check("div_lo", bus.lo_o, 32'hFFFFFFFD);
    check("div_hi", bus.hi_o, 32'hFFFFFFFF);
    drive(1'b1, 2'b10, 6'b010000, 32'd0, 32'd0); #1;
    check("mfhi_done", bus.result, 32'hFFFFFFFF);
    tick();
    run_md(6'b011011, 32'd10, 32'd0, n);
`ifdef ALU_MD_DIV_EARLY_EN
    check("divz_stall", n, 1);
`else
    check("divz_stall", n, 33);
`endif
    check("divz_lo", bus.lo_o, 32'hFFFFFFFF);
    check("divz_hi", bus.hi_o, 32'h0000000A);
    drive(1'b1, 2'b10, 6'b010011, 32'h55, 32'd0);
    tick();
    drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0); #1;
    check("mtlo", bus.result, 32'h55);
    tick();
    drive(1'b1, 2'b10, 6'b010001, 32'h1234, 32'd0);
    tick();
    check("mthi", bus.hi_o, 32'h1234);
    drive(1'b1, 2'b10, 6'b011010, 32'd100, 32'd7); #1;
    check("fl_accept", bus.stall_o, 1);
    repeat (9) tick();
    bus.flush_i = 1'b1; #1;
    check("fl_cycle10", bus.stall_o, 1);
    tick();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0; #1;
    check("fl_stall", bus.stall_o, 0);
    check("fl_hi", bus.hi_o, 32'h1234);
    check("fl_lo", bus.lo_o, 32'h55);
    tick();
    check("fl_idle", bus.stall_o, 0);
    drive(1'b1, 2'b10, 6'b011000, 32'hFFFFFFFD, 32'd5);
    bus.flush_i = 1'b1; #1;
    check("idle_flush", bus.stall_o, 0);
    tick();
    bus.flush_i = 1'b0; #1;
    check("mul_accept", bus.stall_o, 1);
    tick();
    check("mul2_stall", bus.stall_o, 1);
    resetn = 1'b0;
    bus.valid_i = 1'b0; #1;
    check("arst_hi", bus.hi_o, 0);
    check("arst_lo", bus.lo_o, 0);
    check("arst_stall", bus.stall_o, 0);
    #1 resetn = 1'b1;
    tick();
    check("post_rst_stall", bus.stall_o, 0);
    drive(1'b1, 2'b00, 6'd0, 32'd3, 32'd4); #1;
    check("post_rst_add", bus.result, 7);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_md_exec.md
Name: alu_md_exec

Overview:
- Parametrised EX-stage execution unit for the MIPS pipeline; successor to the combinational ALU decode/ALU pair.
- Decodes aluop/funct internally and executes single-cycle ALU ops.
- Adds multi-cycle mult/multu/div/divu with architectural HI/LO registers and a pipeline stall handshake.
- Sits in EX; stall_o feeds the hazard unit.

Parameters:
- WIDTH, 32: datapath width in bits; HI/LO are WIDTH each.
- MUL_STAGES, 2: multiply iteration cycles after accept; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- valid_i  in  1  EX holds a valid instruction.
- flush_i  in  1  EX flush; aborts an in-flight multiply/divide.
- aluop  in  2  00 add, 01 sub, 10 decode funct, 11 reserved.
- funct  in  6  R-type function field.
- src_a  in  WIDTH  operand A / dividend / rs.
- src_b  in  WIDTH  operand B / divisor.
- result  out  WIDTH  ALU result (combinational).
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for funct add (100000) / sub (100010) only.
- stall_o  out  1  hold the pipeline.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Reset (async, resetn=0):
  - hi=lo=0, state IDLE, counters 0, stall_o=0.
  - result=0 while valid_i=0.
- aluop 00 gives a+b; aluop 01 gives a-b. No overflow flag for either.
- aluop 10, single-cycle funct ops, stall_o=0:
  - 100000/100001 add.
  - 100010/100011 sub.
  - 100100 and; 100101 or; 100110 xor; 100111 nor.
  - 101010 slt (signed); 101011 sltu. Result is 1 or 0, zero-extended.
  - 010000 mfhi gives hi; 010010 mflo gives lo.
  - 010001 mthi and 010011 mtlo write src_a at the clock edge when valid_i=1 and stall_o=0.
- Unknown funct and aluop 11: result=0, no HI/LO write, no stall.
- Arithmetic is modulo 2^WIDTH. Product is 2*WIDTH bits, hi=upper half, lo=lower half.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + valid_i + mult/multu (011000/011001): latch operands, cnt=MUL_STAGES-1, go to MUL. stall_o=1 combinationally in this accept cycle.
  - IDLE + valid_i + div/divu (011010/011011): latch operands (absolute values, signs for the signed form), cnt=WIDTH-1, go to DIV. stall_o=1.
  - MUL / DIV: stall_o=1, cnt decrements each cycle. At cnt=0, write hi/lo and go to DONE.
  - DIV uses a restoring radix-2 step, one quotient bit per cycle.
  - DONE: stall_o=0 and the pipeline advances. Always returns to IDLE; valid_i is ignored, so the same op is never re-accepted.
  - Total stall: multiply MUL_STAGES+1 cycles; divide WIDTH+1 cycles.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - lo=quotient, hi=remainder.
- Divide by zero: lo=all ones, hi=dividend. Same cycle count unless the optional feature is enabled.
- flush_i:
  - In MUL or DIV: next state IDLE, stall_o=0 next cycle, hi/lo unchanged.
  - flush_i wins over completion in the same cycle.
  - In IDLE: an op is not accepted in a flush cycle.
- mfhi/mflo in the DONE cycle reads the freshly written hi/lo.
- mthi/mtlo in the same cycle as mfhi/mflo: the read returns the old value.
- resetn asserted mid-operation: immediate abort, registers go to reset values.

Optional Feature:
- Macro: ALU_MD_DIV_EARLY_EN.
- Defined: DIV goes straight to DONE after the accept cycle (total stall 1) when the divisor is 0, or when |dividend| < |divisor| (then lo=0, hi=dividend). Same hi/lo values as the full divide.
- Undefined: a divide always takes WIDTH+1 stall cycles.

Test Plan (WIDTH=32, MUL_STAGES=2, feature off unless stated):
- aluop=10, funct=100000, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, zero=0, stall_o=0.
- mult, a=0xFFFFFFFD, b=5 -> stall_o high 3 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. Following mflo returns 0xFFFFFFF1.
- div, a=0xFFFFFFF9 (-7), b=2 -> stall_o high 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, a=10, b=0 -> lo=0xFFFFFFFF, hi=0x0000000A after 33 stall cycles. With ALU_MD_DIV_EARLY_EN defined, the stall is 1 cycle.
- div accepted after mthi 0x1234, flush_i=1 on the 10th stall cycle -> stall_o=0 next cycle, hi=0x1234, lo unchanged, FSM in IDLE.
- resetn=0 during the 2nd mult cycle -> hi=lo=0, stall_o=0 without waiting for a clock edge. After release, add a=3, b=4 gives result=7.
